// File: rtl/jsv_key_pkg.sv
// Shared types for the keycode command scheduler: command codes, HID usage
// codes of the keys we react to, and the scheduler FSM state encoding.
`timescale 1ns/1ps
package jsv_key_pkg;

    typedef enum logic [3:0] {
        CMD_NONE       = 4'd0,
        CMD_PAN_UP     = 4'd1,
        CMD_PAN_DOWN   = 4'd2,
        CMD_PAN_LEFT   = 4'd3,
        CMD_PAN_RIGHT  = 4'd4,
        CMD_ZOOM_IN    = 4'd5,
        CMD_ZOOM_OUT   = 4'd6,
        CMD_CRE_INC    = 4'd7,
        CMD_CRE_DEC    = 4'd8,
        CMD_CIM_INC    = 4'd9,
        CMD_CIM_DEC    = 4'd10,
        CMD_VIEW_RESET = 4'd11
    } cmd_t;

    localparam logic [7:0] KEY_NONE  = 8'h00;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_Q     = 8'h14;
    localparam logic [7:0] KEY_E     = 8'h08;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_UP    = 8'h52;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_R     = 8'h15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

endpackage

// File: rtl/jsv_key_decode.sv
// Combinational keycode decoder: maps an accepted HID usage code to a
// scheduler command and says whether that command auto-repeats.
`timescale 1ns/1ps
module jsv_key_decode
    import jsv_key_pkg::*;
(
    input  logic [7:0] key_i,
    output cmd_t       cmd_o,
    output logic       repeat_o
);

    // Lookup of the key map; unknown codes and 0x00 decode to CMD_NONE.
    always_comb begin
        cmd_o = CMD_NONE;
        case (key_i)
            KEY_W:     cmd_o = CMD_PAN_UP;
            KEY_S:     cmd_o = CMD_PAN_DOWN;
            KEY_A:     cmd_o = CMD_PAN_LEFT;
            KEY_D:     cmd_o = CMD_PAN_RIGHT;
            KEY_Q:     cmd_o = CMD_ZOOM_IN;
            KEY_E:     cmd_o = CMD_ZOOM_OUT;
            KEY_RIGHT: cmd_o = CMD_CRE_INC;
            KEY_LEFT:  cmd_o = CMD_CRE_DEC;
            KEY_UP:    cmd_o = CMD_CIM_INC;
            KEY_DOWN:  cmd_o = CMD_CIM_DEC;
            KEY_R:     cmd_o = CMD_VIEW_RESET;
            default:   cmd_o = CMD_NONE;
        endcase
        // View reset is a one-shot action; everything else repeats while held.
        repeat_o = (cmd_o != CMD_NONE) && (cmd_o != CMD_VIEW_RESET);
    end

endmodule

// File: rtl/jsv_key_cmd_scheduler.sv
// Keycode command scheduler: debounces the PIO keycode, decodes it into
// navigation commands, paces auto-repeat on frame ticks and presents the
// commands through a single-entry output register.
//
// Output handshake: cmd_valid/cmd_code are held stable while cmd_valid=1 and
// cmd_ready=0; a transfer happens on every clock edge where both are high.
// A new command issued while an untaken one is pending replaces it (latest
// wins) and bumps drop_cnt; an issue coincident with a transfer is not a drop.
`timescale 1ns/1ps
module jsv_key_cmd_scheduler
    import jsv_key_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY  = 15,
    parameter int unsigned REPEAT_RATE   = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] keycode,
    input  logic       frame_tick,
    input  logic       enable,
    output logic       cmd_valid,
    output logic [3:0] cmd_code,
    input  logic       cmd_ready,
    output logic [3:0] held_cmd,
    output logic [7:0] drop_cnt,
    output state_t     dbg_state_o
);

    localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);
    localparam logic [7:0] DELAY_C  = 8'(REPEAT_DELAY);
    localparam logic [7:0] RATE_C   = 8'(REPEAT_RATE);

    // Stability filter state
    logic [7:0] last_key_q;
    logic [7:0] stab_cnt_q, stab_cnt_d;
    logic [7:0] key_q, key_d;
    logic       accept;
    logic       acc_evt_q;

    // Enable edge tracking
    logic       en_q;
    logic       en_rise_q;

    // Scheduler FSM state
    state_t     state_q, state_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       issue;
    cmd_t       issue_code;
    logic       evt;

    // Output register
    logic       valid_q, valid_d;
    cmd_t       code_q, code_d;
    logic [7:0] drop_q, drop_d;

    // Decoded accepted key
    cmd_t       key_cmd;
    logic       key_rep;

    jsv_key_decode u_decode (
        .key_i    (key_q),
        .cmd_o    (key_cmd),
        .repeat_o (key_rep)
    );

    // Count consecutive cycles of the same keycode; accept exactly once per change.
    always_comb begin
        stab_cnt_d = 8'd1;
        if (keycode == last_key_q) begin
            stab_cnt_d = (stab_cnt_q == 8'hFF) ? stab_cnt_q : stab_cnt_q + 8'd1;
        end
        accept = (stab_cnt_d == STABLE_C) && (keycode != key_q);
        key_d  = accept ? keycode : key_q;
    end

    // An acceptance or an enable rising edge both present the held key as new.
    assign evt = acc_evt_q || en_rise_q;

    // Next-state logic of the scheduler and issue generation.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        issue       = 1'b0;
        issue_code  = key_cmd;
        if (!enable) begin
            state_d     = ST_IDLE;
            frame_cnt_d = 8'd0;
        end else if (evt) begin
            if (key_cmd != CMD_NONE) begin
                issue       = 1'b1;
                state_d     = ST_HOLD;
                // A zero count marks a one-shot key: HOLD then ignores ticks.
                frame_cnt_d = key_rep ? DELAY_C : 8'd0;
            end else begin
                state_d     = ST_IDLE;
                frame_cnt_d = 8'd0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    frame_cnt_d = 8'd0;
                end
                ST_HOLD: begin
                    if (frame_tick && (frame_cnt_q != 8'd0)) begin
                        if (frame_cnt_q == 8'd1) begin
                            issue       = 1'b1;
                            state_d     = ST_REPEAT;
                            frame_cnt_d = RATE_C;
                        end else begin
                            frame_cnt_d = frame_cnt_q - 8'd1;
                        end
                    end
                end
                ST_REPEAT: begin
                    if (frame_tick) begin
                        if (frame_cnt_q <= 8'd1) begin
                            issue       = 1'b1;
                            frame_cnt_d = RATE_C;
                        end else begin
                            frame_cnt_d = frame_cnt_q - 8'd1;
                        end
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    frame_cnt_d = 8'd0;
                end
            endcase
        end
    end

    // Single-entry output register with overwrite and saturating drop count.
    always_comb begin
        valid_d = valid_q;
        code_d  = code_q;
        drop_d  = drop_q;
        if (issue) begin
            valid_d = 1'b1;
            code_d  = issue_code;
            if (valid_q && !cmd_ready && (drop_q != 8'hFF)) begin
                drop_d = drop_q + 8'd1;
            end
        end else if (valid_q && cmd_ready) begin
            valid_d = 1'b0;
        end
    end

    // All state registers, cleared asynchronously by reset_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_key_q  <= 8'd0;
            stab_cnt_q  <= 8'd0;
            key_q       <= 8'd0;
            acc_evt_q   <= 1'b0;
            en_q        <= 1'b0;
            en_rise_q   <= 1'b0;
            state_q     <= ST_IDLE;
            frame_cnt_q <= 8'd0;
            valid_q     <= 1'b0;
            code_q      <= CMD_NONE;
            drop_q      <= 8'd0;
        end else begin
            last_key_q  <= keycode;
            stab_cnt_q  <= stab_cnt_d;
            key_q       <= key_d;
            acc_evt_q   <= accept;
            en_q        <= enable;
            en_rise_q   <= enable && !en_q;
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            valid_q     <= valid_d;
            code_q      <= code_d;
            drop_q      <= drop_d;
        end
    end

    assign cmd_valid   = valid_q;
    assign cmd_code    = code_q;
    assign drop_cnt    = drop_q;
    assign held_cmd    = enable ? key_cmd : CMD_NONE;
    assign dbg_state_o = state_q;

endmodule
